button_conditioner: RTL and testbench

//  Front end for the board's three push buttons (left/right/put), sitting directly upstream of the game core.
//  Per button: synchronises the raw pin, debounces it, and emits one-cycle pulses.

---
 rtl/score4_pkg.sv | 18 +
 rtl/debounce_cell.sv | 53 +++++
 rtl/button_conditioner.sv | 129 ++++++++++++
 tb/tb_button_conditioner.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/score4_pkg.sv
// Shared constants and types for the score4 push-button front end.
package score4_pkg;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_PUT   = 2;

  localparam int DEBOUNCE_CYCLES_DEF = 500_000;
  localparam int REPEAT_DELAY_DEF    = 25_000_000;
  localparam int REPEAT_PERIOD_DEF   = 10_000_000;

  typedef enum logic [1:0] {
    RP_IDLE   = 2'd0,
    RP_DELAY  = 2'd1,
    RP_REPEAT = 2'd2
  } rep_state_t;

endpackage

// File: rtl/debounce_cell.sv
// One button lane: two-flop synchroniser, polarity fix, debounce counter and
// debounced level. held_next/rising are the values held takes at the next edge,
// so the top can register its pulse in the same cycle held first reads 1.
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic held,
  output logic held_next,
  output logic rising
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic             level;
  logic             expire;
  logic [CNT_W-1:0] count;

  assign level     = ACTIVE_LOW ? ~sync[1] : sync[1];
  assign expire    = (level != held) && (count == CNT_LAST);
  assign held_next = expire ? level : held;
  assign rising    = expire & level;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= 2'b00;
    end else begin
      sync <= {sync[0], raw};
    end
  end

  // Accept a new level only after it has disagreed with held long enough.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      held  <= 1'b0;
    end else if (level == held) begin
      count <= '0;
    end else if (expire) begin
      count <= '0;
      held  <= level;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions the left/right/put buttons for the game core: debounced press
// strobes, hold-to-repeat on the move buttons, enable gating and left/right
// conflict suppression. All pulses are registered.
module button_conditioner
  import score4_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       left,
  input  logic       right,
  input  logic       put,
  output logic       left_pulse,
  output logic       right_pulse,
  output logic       put_pulse,
  output logic [2:0] held
);

  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = (RP_MAX < 2) ? 1 : $clog2(RP_MAX);
  localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

  logic [2:0] raw;
  logic [2:0] held_next;
  logic [2:0] rising;

  assign raw[BTN_LEFT]  = left;
  assign raw[BTN_RIGHT] = right;
  assign raw[BTN_PUT]   = put;

  for (genvar i = 0; i < 3; i++) begin : g_btn
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .raw      (raw[i]),
      .held     (held[i]),
      .held_next(held_next[i]),
      .rising   (rising[i])
    );
  end

  rep_state_t      state   [2];
  rep_state_t      state_d [2];
  logic [RP_W-1:0] cnt     [2];
  logic [RP_W-1:0] cnt_d   [2];
  logic [1:0]      move;

  // Next state of the left/right repeat FSMs and the move strobe for the next cycle.
  always_comb begin
    move = 2'b00;
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state[i];
      cnt_d[i]   = cnt[i];
      if (!held_next[i] || !enable) begin
        state_d[i] = RP_IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state[i])
          RP_IDLE: begin
            if (rising[i]) begin
              move[i] = 1'b1;
              cnt_d[i] = '0;
              if (REPEAT_DELAY != 0) state_d[i] = RP_DELAY;
            end
          end
          RP_DELAY: begin
            if (cnt[i] == DELAY_LAST) begin
              move[i]    = 1'b1;
              state_d[i] = RP_REPEAT;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt[i] + 1'b1;
            end
          end
          RP_REPEAT: begin
            if (cnt[i] == PERIOD_LAST) begin
              move[i]  = 1'b1;
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt[i] + 1'b1;
            end
          end
          default: begin
            state_d[i] = RP_IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
    if (move[BTN_LEFT] && move[BTN_RIGHT]) begin
      move = 2'b00;
      for (int i = 0; i < 2; i++) begin
        state_d[i] = RP_IDLE;
        cnt_d[i]   = '0;
      end
    end
  end

  // Register FSM state and all three output strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        state[i] <= RP_IDLE;
        cnt[i]   <= '0;
      end
      left_pulse  <= 1'b0;
      right_pulse <= 1'b0;
      put_pulse   <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state[i] <= state_d[i];
        cnt[i]   <= cnt_d[i];
      end
      left_pulse  <= move[BTN_LEFT];
      right_pulse <= move[BTN_RIGHT];
      put_pulse   <= rising[BTN_PUT] & enable;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed testbench for button_conditioner with small debounce/repeat timings.
module tb_button_conditioner;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       left;
  logic       right;
  logic       put;
  logic       left_pulse;
  logic       right_pulse;
  logic       put_pulse;
  logic [2:0] held;

  int test_count = 0;
  int fail_count = 0;
  int cyc = 0;
  int left_q[$];
  int right_q[$];
  int put_q[$];
  logic [2:0] held_seen = 3'b000;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (8),
    .REPEAT_PERIOD  (4),
    .ACTIVE_LOW     (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .left       (left),
    .right      (right),
    .put        (put),
    .left_pulse (left_pulse),
    .right_pulse(right_pulse),
    .put_pulse  (put_pulse),
    .held       (held)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle number: value seen between posedge and the next posedge.
  always @(posedge clk) cyc <= cyc + 1;

  // Log the cycle of every strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (left_pulse)  left_q.push_back(cyc);
    if (right_pulse) right_q.push_back(cyc);
    if (put_pulse)   put_q.push_back(cyc);
    held_seen = held_seen | held;
  end

  // Safety net against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic l, input logic r, input logic p, input logic en);
    left   = l;
    right  = r;
    put    = p;
    enable = en;
  endtask

  task automatic clearLogs();
    left_q.delete();
    right_q.delete();
    put_q.delete();
    held_seen = 3'b000;
  endtask

  int c0;
  int exp_right[9] = '{6, 14, 18, 22, 26, 30, 34, 38, 42};

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(2);
    checkOutput("reset held", 32'(held), 0);
    checkOutput("reset pulses", 32'({left_pulse, right_pulse, put_pulse}), 0);
    rst = 1'b1;
    waitCycles(4);

    // put press: pulse 6 cycles after the raw edge, held from the same cycle
    clearLogs();
    c0 = cyc;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    waitCycles(5);
    checkOutput("put held early", 32'(held[2]), 0);
    waitCycles(1);
    checkOutput("put held rise", 32'(held[2]), 1);
    waitCycles(6);
    checkOutput("put pulse count", put_q.size(), 1);
    if (put_q.size() > 0) checkOutput("put pulse cycle", put_q[0] - c0, 6);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(10);
    checkOutput("put release no pulse", put_q.size(), 1);
    checkOutput("put released held", 32'(held), 0);

    // 3-cycle glitch is filtered out
    clearLogs();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    waitCycles(3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(10);
    checkOutput("glitch3 held seen", 32'(held_seen), 0);
    checkOutput("glitch3 pulses", left_q.size(), 0);

    // 4-cycle glitch gives one pulse; held falls 6 cycles after release
    clearLogs();
    c0 = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    waitCycles(4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(5);
    checkOutput("glitch4 held before fall", 32'(held[0]), 1);
    waitCycles(1);
    checkOutput("glitch4 held fall", 32'(held[0]), 0);
    waitCycles(10);
    checkOutput("glitch4 pulse count", left_q.size(), 1);
    if (left_q.size() > 0) checkOutput("glitch4 pulse cycle", left_q[0] - c0, 6);

    // right held 40 cycles: press, delayed first repeat, then periodic repeats
    clearLogs();
    c0 = cyc;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    waitCycles(40);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(20);
    checkOutput("repeat count", right_q.size(), 9);
    for (int k = 0; k < 9; k++) begin
      checkOutput($sformatf("repeat pulse %0d", k), (k < right_q.size()) ? right_q[k] - c0 : -1, exp_right[k]);
    end
    checkOutput("repeat no left", left_q.size(), 0);

    // left and right together: both suppressed, no repeats either
    clearLogs();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    waitCycles(24);
    checkOutput("conflict held", 32'(held[1:0]), 3);
    checkOutput("conflict left", left_q.size(), 0);
    checkOutput("conflict right", right_q.size(), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(10);

    // put and left together: both pulse in the same cycle
    clearLogs();
    c0 = cyc;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    waitCycles(8);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(12);
    checkOutput("combo left count", left_q.size(), 1);
    checkOutput("combo put count", put_q.size(), 1);
    if (left_q.size() > 0) checkOutput("combo left cycle", left_q[0] - c0, 6);
    if (put_q.size() > 0) checkOutput("combo put cycle", put_q[0] - c0, 6);

    // press while disabled, then enable while still held: silent
    clearLogs();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    waitCycles(10);
    checkOutput("disabled held", 32'(held[0]), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    waitCycles(20);
    checkOutput("enable late pulses", left_q.size(), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(10);

    // drop enable during repeat: repeats stop at once
    clearLogs();
    c0 = cyc;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    waitCycles(16);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitCycles(14);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    waitCycles(10);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(10);
    checkOutput("enable drop count", right_q.size(), 2);
    if (right_q.size() > 1) checkOutput("enable drop last", right_q[1] - c0, 14);

    // async reset during a pulse, button held through reset release
    clearLogs();
    c0 = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    waitCycles(6);
    checkOutput("pre-reset pulse", 32'(left_pulse), 1);
    rst = 1'b0;
    #1;
    checkOutput("reset async pulse", 32'(left_pulse), 0);
    checkOutput("reset async held", 32'(held), 0);
    waitCycles(3);
    clearLogs();
    rst = 1'b1;
    c0 = cyc;
    waitCycles(10);
    checkOutput("post-reset pulse count", left_q.size(), 1);
    if (left_q.size() > 0) checkOutput("post-reset pulse cycle", left_q[0] - c0, 6);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    waitCycles(10);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
